probe_capture: RTL and testbench

PROBE_CAPTURE -- requirements
Module: probe_capture

---
 rtl/probe_capture_if.sv | 14 +
 rtl/probe_capture.sv | 182 ++++++++++++++++++
 tb/tb_probe_capture.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/probe_capture_if.sv
// Readout stream of the probe capture buffer (valid/ready).
//   master: drives rd_valid, rd_data, rd_last; receives rd_ready
//   slave : receives rd_valid, rd_data, rd_last; drives rd_ready
interface probe_capture_if #(
    parameter int unsigned PROBE_W = 45
);
    logic               rd_valid;
    logic               rd_ready;
    logic [PROBE_W-1:0] rd_data;
    logic               rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/probe_capture.sv
// probe_capture: logic-analyser style capture buffer. After arm, it records
// PRE_TRIG samples of history, waits for a masked trigger match, records the
// rest of the window and then streams DEPTH words out in time order.
//
// Ports:
//   sys_clk, rst            clock, asynchronous active-high reset
//   probe_data              sampled every cycle while capturing
//   trig_mask, trig_value   trigger compare: (probe & mask) == (value & mask)
//   arm                     one-cycle start pulse (IDLE only)
//   abort                   return to IDLE from any state, wins over all
//   trig_edge               (only with PROBE_CAPTURE_EDGE_TRIG_EN) rising-match trigger
//   rd                      readout stream (probe_capture_if.master)
//   busy                    capturing (PREFILL, ARMED, POST)
//   done                    READOUT in progress
//   trig_addr               buffer address of the trigger sample
//
// Optional feature macro: PROBE_CAPTURE_EDGE_TRIG_EN (edge-qualified trigger).
module probe_capture #(
    parameter int unsigned PROBE_W  = 45,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned PRE_TRIG = 256
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic [PROBE_W-1:0]         probe_data,
    input  logic [PROBE_W-1:0]         trig_mask,
    input  logic [PROBE_W-1:0]         trig_value,
    input  logic                       arm,
    input  logic                       abort,
`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
    input  logic                       trig_edge,
`endif
    probe_capture_if.master            rd,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   trig_addr
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam int unsigned POST_LEN = DEPTH - PRE_TRIG - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_ARMED,
        S_POST,
        S_READOUT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PROBE_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      cnt;
    logic               match_c;
    logic               trig_c;
    logic               wr_en_c;
    logic               rd_load_c;
    logic [AW-1:0]      rd_start_c;

    assign match_c = ((probe_data ^ trig_value) & trig_mask) == '0;

`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
    // Match result of the previous sampled cycle; seeded to 1 on arm so a
    // zero-length prefill cannot fire on an already-true condition.
    logic match_prev;
    assign trig_c = match_c && !(trig_edge && match_prev);
`else
    assign trig_c = match_c;
`endif

    // Oldest word of the window; in ARMED the trigger address is wr_ptr itself.
    assign rd_start_c = ((state == S_ARMED) ? wr_ptr : trig_addr) - AW'(PRE_TRIG);

    // Next-state and per-cycle strobes
    always_comb begin
        state_nxt = state;
        wr_en_c   = 1'b0;
        rd_load_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) state_nxt = (PRE_TRIG == 0) ? S_ARMED : S_PREFILL;
            end
            S_PREFILL: begin
                wr_en_c = 1'b1;
                if (cnt == CW'(PRE_TRIG - 1)) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                wr_en_c = 1'b1;
                if (trig_c) state_nxt = (POST_LEN == 0) ? S_READOUT : S_POST;
            end
            S_POST: begin
                wr_en_c = 1'b1;
                if (cnt == CW'(POST_LEN - 1)) state_nxt = S_READOUT;
            end
            S_READOUT: begin
                // Refill the output register when it is empty or being consumed.
                rd_load_c = (!rd.rd_valid || rd.rd_ready) && (cnt != CW'(DEPTH));
                if (rd.rd_valid && rd.rd_ready && rd.rd_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            wr_en_c   = 1'b0;
            rd_load_c = 1'b0;
        end
    end

    // State, pointers, counters and registered status
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            trig_addr   <= '0;
            rd.rd_valid <= 1'b0;
            rd.rd_last  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
            match_prev  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            busy  <= state_nxt inside {S_PREFILL, S_ARMED, S_POST};
            done  <= (state_nxt == S_READOUT);

            if (wr_en_c) wr_ptr <= wr_ptr + AW'(1);

            case (state)
                S_IDLE: begin
                    if (arm && !abort) begin
                        wr_ptr <= '0;
                        cnt    <= '0;
                    end
                end
                S_PREFILL: cnt <= cnt + CW'(1);
                S_ARMED: begin
                    if (trig_c && !abort) begin
                        trig_addr <= wr_ptr;
                        cnt       <= '0;
                    end
                end
                S_POST:  cnt <= cnt + CW'(1);
                default: ;
            endcase

            if (state_nxt == S_READOUT && state != S_READOUT) begin
                rd_ptr <= rd_start_c;
                cnt    <= '0;
            end

            if (rd_load_c) begin
                rd.rd_valid <= 1'b1;
                rd.rd_last  <= (cnt == CW'(DEPTH - 1));
                rd_ptr      <= rd_ptr + AW'(1);
                cnt         <= cnt + CW'(1);
            end else if (rd.rd_ready || state_nxt != S_READOUT) begin
                rd.rd_valid <= 1'b0;
                rd.rd_last  <= 1'b0;
            end

`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
            if (state == S_IDLE && arm) begin
                match_prev <= 1'b1;
            end else if (state == S_PREFILL || state == S_ARMED) begin
                match_prev <= match_c;
            end
`endif
        end
    end

    // Capture memory and registered read port (no reset: contents are data only)
    always_ff @(posedge sys_clk) begin
        if (wr_en_c)   mem[wr_ptr] <= probe_data;
        if (rd_load_c) rd.rd_data  <= mem[rd_ptr];
    end

endmodule

// File: tb/tb_probe_capture.sv
// Bench for probe_capture: DEPTH=16, PRE_TRIG=4, 16-bit probe. The model
// computes the expected window from the stimulus stream and the trigger rule.
module tb_probe_capture;
    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PRE   = 4;
    localparam int unsigned AW    = 4;
    localparam int unsigned NSTIM = 256;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic [W-1:0]  probe_data;
    logic [W-1:0]  trig_mask;
    logic [W-1:0]  trig_value;
    logic          arm;
    logic          abort;
`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
    logic          trig_edge;
`endif
    logic          busy;
    logic          done;
    logic [AW-1:0] trig_addr;

    probe_capture_if #(.PROBE_W(W)) rd_if ();

    probe_capture #(.PROBE_W(W), .DEPTH(DEPTH), .PRE_TRIG(PRE)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .probe_data (probe_data),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .arm        (arm),
        .abort      (abort),
`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
        .trig_edge  (trig_edge),
`endif
        .rd         (rd_if),
        .busy       (busy),
        .done       (done),
        .trig_addr  (trig_addr)
    );

    always #5 sys_clk = ~sys_clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] stim [NSTIM];
    logic [W-1:0] exp_q [$];
    int           exp_taddr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_match(input logic [W-1:0] v, input logic [W-1:0] m, input logic [W-1:0] t);
        return ((v & m) == (t & m));
    endfunction

    // Window = PRE samples before the first qualifying sample, that sample,
    // and the following DEPTH-PRE-1 samples.
    task automatic build_model(input logic [W-1:0] m, input logic [W-1:0] t, input bit edge_mode);
        int  idx;
        bit  prev;
        idx = -1;
        exp_q.delete();
        for (int k = PRE; k < int'(NSTIM - DEPTH); k++) begin
            prev = (k == 0) ? 1'b1 : is_match(stim[k-1], m, t);
            if (is_match(stim[k], m, t) && !(edge_mode && prev)) begin
                idx = k;
                break;
            end
        end
        if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL model_trigger: got none expected a trigger in stimulus");
        end else begin
            for (int j = idx - int'(PRE); j < idx - int'(PRE) + int'(DEPTH); j++) exp_q.push_back(stim[j]);
            exp_taddr = idx % int'(DEPTH);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},     64'(busy), 64'(0));
        check({tag, "_done"},     64'(done), 64'(0));
        check({tag, "_rd_valid"}, 64'(rd_if.rd_valid), 64'(0));
    endtask

    task automatic run_capture(input string tag, input logic [W-1:0] m, input logic [W-1:0] t,
                               input bit edge_mode, input bit stall);
        int k;
        int cyc;
        trig_mask  = m;
        trig_value = t;
`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
        trig_edge  = edge_mode;
`endif
        @(posedge sys_clk); #1;
        arm        = 1'b1;
        probe_data = '1;
        k   = 0;
        cyc = 0;
        do begin
            @(posedge sys_clk); #1;
            arm        = 1'b0;
            probe_data = (k < int'(NSTIM)) ? stim[k] : '0;
            k++;
            rd_if.rd_ready = stall ? ($urandom_range(0, 99) < 30) : 1'b1;
            cyc++;
        end while (!(exp_q.size() == 0 && !busy && !done) && cyc < 3000);
        check({tag, "_words_left"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_trig_addr"},  64'(trig_addr), 64'(exp_taddr));
        check_idle({tag, "_end"});
        rd_if.rd_ready = 1'b1;
    endtask

    // Output checker: every transfer against the model, stability while stalled.
    logic [W-1:0] held_data;
    logic         held_last;
    bit           stalled = 1'b0;
    always @(negedge sys_clk) begin
        logic [W-1:0] e;
        if (rst !== 1'b0) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 64'(rd_if.rd_valid), 64'(1));
                check("stall_data",  64'(rd_if.rd_data),  64'(held_data));
                check("stall_last",  64'(rd_if.rd_last),  64'(held_last));
            end
            if (rd_if.rd_valid) check("done_with_valid", 64'(done), 64'(1));
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_word: got %0h expected no transfer", rd_if.rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 64'(rd_if.rd_data), 64'(e));
                    check("rd_last", 64'(rd_if.rd_last), 64'(exp_q.size() == 0));
                end
            end
            stalled   = rd_if.rd_valid && !rd_if.rd_ready;
            held_data = rd_if.rd_data;
            held_last = rd_if.rd_last;
        end
    end

    initial begin
        int saved_taddr;
        for (int k = 0; k < int'(NSTIM); k++) stim[k] = W'(k);
        rst            = 1'b0;
        arm            = 1'b0;
        abort          = 1'b0;
        probe_data     = '0;
        trig_mask      = '0;
        trig_value     = '0;
        rd_if.rd_ready = 1'b0;
`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
        trig_edge      = 1'b0;
`endif
        #1 rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check_idle("reset");
        check("reset_rd_last",   64'(rd_if.rd_last), 64'(0));
        check("reset_trig_addr", 64'(trig_addr), 64'(0));
        rst            = 1'b0;
        rd_if.rd_ready = 1'b1;

        // Scenario 1: trigger on value 20 -> words 16..31
        build_model('1, W'(20), 1'b0);
        check("s1_model_first", 64'(exp_q[0]), 64'(16));
        check("s1_model_last",  64'(exp_q[DEPTH-1]), 64'(31));
        run_capture("s1", '1, W'(20), 1'b0, 1'b0);
        check("s1_trig_addr_lit", 64'(trig_addr), 64'(4));

        // Scenario 2: zero mask triggers on the first ARMED sample
        build_model('0, W'(20), 1'b0);
        check("s2_model_first", 64'(exp_q[0]), 64'(0));
        check("s2_model_last",  64'(exp_q[DEPTH-1]), 64'(15));
        run_capture("s2", '0, W'(20), 1'b0, 1'b0);

        // Scenario 3: trigger at 100, readout wraps the buffer
        build_model('1, W'(100), 1'b0);
        check("s3_model_first", 64'(exp_q[0]), 64'(96));
        check("s3_model_last",  64'(exp_q[DEPTH-1]), 64'(111));
        run_capture("s3", '1, W'(100), 1'b0, 1'b0);
        check("s3_trig_addr_lit", 64'(trig_addr), 64'(4));

        // Scenario 4: random 30% ready duty during readout
        build_model('1, W'(50), 1'b0);
        run_capture("s4", '1, W'(50), 1'b0, 1'b1);
        check("s4_trig_addr_lit", 64'(trig_addr), 64'(2));
        saved_taddr = 2;

        // Scenario 5a: abort (with arm) in the trigger cycle
        trig_mask  = '1;
        trig_value = W'(25);
        @(posedge sys_clk); #1;
        arm = 1'b1;
        for (int k = 0; k <= 25; k++) begin
            @(posedge sys_clk); #1;
            arm        = 1'b0;
            probe_data = stim[k];
            if (k == 25) begin
                abort = 1'b1;
                arm   = 1'b1;
            end
        end
        @(posedge sys_clk); #1;
        abort = 1'b0;
        arm   = 1'b0;
        check_idle("s5_abort");
        check("s5_abort_trig_addr", 64'(trig_addr), 64'(saved_taddr));
        repeat (3) @(posedge sys_clk);
        #1;
        check_idle("s5_abort_settle");

        // Arm together with abort in IDLE is ignored
        arm   = 1'b1;
        abort = 1'b1;
        @(posedge sys_clk); #1;
        arm   = 1'b0;
        abort = 1'b0;
        check_idle("s5_arm_abort");

        // Scenario 5b: reset mid-POST
        trig_value = W'(20);
        arm        = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            @(posedge sys_clk); #1;
            arm        = 1'b0;
            probe_data = stim[k];
        end
        check("s5_post_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check_idle("s5_rst");
        check("s5_rst_trig_addr", 64'(trig_addr), 64'(0));
        @(posedge sys_clk); #1;
        rst = 1'b0;

        // Recovery after reset
        build_model('1, W'(20), 1'b0);
        run_capture("s5_recover", '1, W'(20), 1'b0, 1'b0);

`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
        // Scenario 6: match already true when ARMED is entered; fires on the
        // next rising match (sample 13)
        for (int k = 0; k < int'(NSTIM); k++)
            stim[k] = W'(k) | ((k < 10 || k >= 13) ? W'(16'h8000) : W'(0));
        build_model(W'(16'h8000), W'(16'h8000), 1'b1);
        check("s6_model_taddr", 64'(exp_taddr), 64'(13));
        check("s6_model_first", 64'(exp_q[0]), 64'(16'h8009));
        run_capture("s6", W'(16'h8000), W'(16'h8000), 1'b1, 1'b0);
        check("s6_trig_addr_lit", 64'(trig_addr), 64'(13));
        for (int k = 0; k < int'(NSTIM); k++) stim[k] = W'(k);
`endif

        repeat (2) @(posedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
